// File: rtl/instr_prefetch_queue.sv
// Sequential instruction prefetcher: req/gnt+rvalid fetch port feeding a DEPTH-entry FIFO presented to the core.
// Latency: a response is visible on o_instr the cycle after rvalid (no bypass); first request one cycle after reset release.
// Backpressure: requests stop while fifo_count + outstanding == DEPTH; a redirect drops the FIFO and stale in-flight responses.
module instr_prefetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        i_reset_n,
  output logic        o_mem_req,
  output logic [31:0] o_mem_addr,
  input  logic        i_mem_gnt,
  input  logic        i_mem_rvalid,
  input  logic [31:0] i_mem_rdata,
  output logic [31:0] o_instr,
  output logic [31:0] o_instr_pc,
  output logic        o_instr_valid,
  input  logic        i_instr_ready,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  typedef enum logic [0:0] {FETCH = 1'b0, FLUSH = 1'b1} state_t;

  state_t        state, state_nxt;
  logic          run;
  logic [31:0]   fetch_pc, resp_pc, redirect_word_pc;
  logic [AW:0]   count, outstanding, outstanding_nxt, discard, discard_nxt;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [31:0]   data_q [DEPTH];
  logic [31:0]   pc_q   [DEPTH];
  logic          credit_ok, grant, enq, deq;

  assign redirect_word_pc = i_redirect_pc & 32'hFFFF_FFFC;
  assign credit_ok        = ({1'b0, count} + {1'b0, outstanding}) < (AW+2)'(DEPTH);
  assign o_mem_addr       = fetch_pc;
  assign o_instr          = data_q[rd_ptr];
  assign o_instr_pc       = pc_q[rd_ptr];
  assign o_instr_valid    = (count != '0);

  // Next state, request gating and discard tracking; a same-cycle rvalid counts as returned on redirect.
  always_comb begin
    state_nxt       = state;
    discard_nxt     = discard;
    outstanding_nxt = outstanding;
    o_mem_req       = (state == FETCH) && run && credit_ok && !i_redirect;
    grant           = o_mem_req && i_mem_gnt;
    enq             = i_mem_rvalid && (state == FETCH) && !i_redirect;
    deq             = o_instr_valid && i_instr_ready && !i_redirect;
    if (grant && !i_mem_rvalid) begin
      outstanding_nxt = outstanding + CNT_ONE;
    end else if (!grant && i_mem_rvalid) begin
      outstanding_nxt = outstanding - CNT_ONE;
    end
    if (i_redirect) begin
      discard_nxt = outstanding_nxt;
      state_nxt   = (outstanding_nxt != '0) ? FLUSH : FETCH;
    end else if (state == FLUSH) begin
      if (i_mem_rvalid) begin
        discard_nxt = discard - CNT_ONE;
      end
      if (discard_nxt == '0) begin
        state_nxt = FETCH;
      end
    end
  end

  // State register; run holds requests off until the first edge after reset release.
  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state <= FETCH;
      run   <= 1'b0;
    end else begin
      state <= state_nxt;
      run   <= 1'b1;
    end
  end

  // Fetch/response PCs and credit counters.
  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      outstanding <= outstanding_nxt;
      discard     <= discard_nxt;
      if (i_redirect) begin
        fetch_pc <= redirect_word_pc;
        resp_pc  <= redirect_word_pc;
      end else begin
        if (grant) fetch_pc <= fetch_pc + 32'd4;
        if (enq)   resp_pc  <= resp_pc + 32'd4;
      end
    end
  end

  // Instruction FIFO; a redirect empties it and overrides any same-cycle dequeue.
  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        pc_q[i]   <= '0;
      end
    end else if (i_redirect) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) begin
        data_q[wr_ptr] <= i_mem_rdata;
        pc_q[wr_ptr]   <= resp_pc;
        wr_ptr         <= wr_ptr + PTR_ONE;
      end
      if (deq) rd_ptr <= rd_ptr + PTR_ONE;
      if (enq && !deq)      count <= count + CNT_ONE;
      else if (!enq && deq) count <= count - CNT_ONE;
    end
  end

endmodule
